// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing defaults and helpers for the timing generator
// and anything positioned in screen coordinates (e.g. sprites).
package vga_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned VGA_CLK_DIV  = 4;
    localparam int unsigned VGA_SYNC_DLY = 2;

    localparam int unsigned VGA_H_VIS  = 640;
    localparam int unsigned VGA_H_FP   = 16;
    localparam int unsigned VGA_H_SYNC = 96;
    localparam int unsigned VGA_H_BP   = 48;
    localparam int unsigned VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_VIS  = 480;
    localparam int unsigned VGA_V_FP   = 10;
    localparam int unsigned VGA_V_SYNC = 2;
    localparam int unsigned VGA_V_BP   = 33;
    localparam int unsigned VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        SEG_VIS,
        SEG_FP,
        SEG_SYNC,
        SEG_BP
    } seg_e;

    // Classify a line/pixel position into its timing segment; anything past
    // the sync pulse is back porch.
    function automatic seg_e seg_of(input coord_t pos,
                                    input int unsigned vis,
                                    input int unsigned fp,
                                    input int unsigned sync);
        int unsigned p;
        p = 32'(pos);
        if (p < vis)
            return SEG_VIS;
        else if (p < vis + fp)
            return SEG_FP;
        else if (p < vis + fp + sync)
            return SEG_SYNC;
        else
            return SEG_BP;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Single-bit shift register of configurable depth whose stages all load a
// configurable inactive value during reset.
module sig_delay #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_pass
            // No register stage: still present the inactive value while in reset.
            assign q = rst_n ? d : RST_VAL;
        end else begin : g_shift
            logic [DEPTH-1:0] sr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= {DEPTH{RST_VAL}};
                end else begin
                    sr[0] <= d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel strobe, undelayed x/y counters and a
// frame-start pulse, plus sync/visible flags delayed to match pixel pipelines.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_VIS    = VGA_H_VIS,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_VIS    = VGA_V_VIS,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned SYNC_DLY = VGA_SYNC_DLY
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         pix_en,
    output logic [9:0]   x,
    output logic [9:0]   y,
    output logic         video_on,
    output logic         hsync,
    output logic         vsync,
    output logic         frame_start
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam coord_t           X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam coord_t           Y_LAST   = COORD_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div;
    logic             run;
    seg_e             hseg;
    seg_e             vseg;
    logic             raw_video_on;
    logic             raw_hsync;
    logic             raw_vsync;

    // run keeps the strobe low during reset even when CLK_DIV is 1.
    assign pix_en = run && (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            if (div == DIV_LAST)
                div <= '0;
            else
                div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                if (x == X_LAST) begin
                    x <= '0;
                    if (y == Y_LAST) begin
                        y           <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        y <= y + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hseg         = seg_of(x, H_VIS, H_FP, H_SYNC);
        vseg         = seg_of(y, V_VIS, V_FP, V_SYNC);
        raw_video_on = (hseg == SEG_VIS) && (vseg == SEG_VIS);
        raw_hsync    = (hseg != SEG_SYNC);
        raw_vsync    = (vseg != SEG_SYNC);
    end

    sig_delay #(.DEPTH(SYNC_DLY), .RST_VAL(1'b0)) u_dly_video_on (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_video_on),
        .q     (video_on)
    );

    sig_delay #(.DEPTH(SYNC_DLY), .RST_VAL(1'b1)) u_dly_hsync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_hsync),
        .q     (hsync)
    );

    sig_delay #(.DEPTH(SYNC_DLY), .RST_VAL(1'b1)) u_dly_vsync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_vsync),
        .q     (vsync)
    );

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter CLK_DIV, 4, system clocks per pixel; 100 MHz clk gives 25 MHz pixel rate.
REQ-002 Parameters H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal segment lengths in pixels (H_TOTAL=800).
REQ-003 Parameters V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical segment lengths in lines (V_TOTAL=525).
REQ-004 Parameter SYNC_DLY, 2, clk cycles of delay on hsync/vsync/video_on to match sprite addr-plus-ROM latency; legal range 0..7.
REQ-005 clk  in  1  system clock; all state advances on its rising edge.
REQ-006 rst_n  in  1  reset; one clock, asynchronous assert, active-low.
REQ-007 pix_en  out  1  one-clk pixel strobe, high once every CLK_DIV clocks; drives sprite en.
REQ-008 x  out  10  current horizontal count 0..H_TOTAL-1, undelayed; feeds sprite x.
REQ-009 y  out  10  current vertical count 0..V_TOTAL-1, undelayed; feeds sprite y.
REQ-010 video_on  out  1  visible-region flag, delayed SYNC_DLY clks.
REQ-011 hsync  out  1  active-low horizontal sync, delayed SYNC_DLY clks.
REQ-012 vsync  out  1  active-low vertical sync, delayed SYNC_DLY clks.
REQ-013 frame_start  out  1  one-clk pulse when the counters enter (x=0, y=0), undelayed.

Function
REQ-014 Divider counts 0..CLK_DIV-1 and wraps; pix_en SHALL be high exactly when divider = CLK_DIV-1.
REQ-015 x SHALL increment only on clocks with pix_en high; at H_TOTAL-1 it SHALL wrap to 0 on the same edge that increments y.
REQ-016 y SHALL change only on an x wrap; at V_TOTAL-1 it SHALL wrap to 0.
REQ-017 Raw video_on SHALL equal (x < H_VIS) AND (y < V_VIS).
REQ-018 Raw hsync SHALL be low iff H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC (656..751 at defaults).
REQ-019 Raw vsync SHALL be low iff V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC (490..491 at defaults).
REQ-020 Raw signals SHALL pass through a SYNC_DLY-deep shift register clocked every clk (not gated by pix_en); with SYNC_DLY=0 the outputs SHALL equal the raw values.
REQ-021 frame_start SHALL be high for exactly the one clk on which x and y both become 0 (the wrap edge), and on no other clock.
REQ-022 x and y SHALL hold their value for CLK_DIV clks between updates; no glitch or intermediate value is permitted.
REQ-023 Counter arithmetic is unsigned 10-bit; compares use full width; no value >= H_TOTAL or >= V_TOTAL SHALL ever appear.

Reset
REQ-024 While rst_n is low: divider=0, x=0, y=0, pix_en=0, frame_start=0, video_on=0, hsync=1, vsync=1, all delay stages loaded with the inactive values (video_on 0, syncs 1).
REQ-025 Reset asserted mid-frame SHALL force the REQ-024 values asynchronously, without waiting for a clk edge.
REQ-026 On the first clk after rst_n rises, counting resumes from divider=0; the first pix_en occurs on the CLK_DIV-th clk; no frame_start is issued for the reset origin.

Structure
REQ-027 Default VGA 640x480 timing constants and the derived H_TOTAL/V_TOTAL SHALL live in a shared package (vga_pkg), also used by sprite position parameters.
REQ-028 One sub-module SHALL be natural: sig_delay (parameterised-depth, parameterised-reset-value shift register), instantiated for video_on, hsync and vsync.

Verification
REQ-029 Reset: hold rst_n low 10 clks -> x=0, y=0, hsync=1, vsync=1, video_on=0, pix_en=0 throughout; first pix_en on clk 4 after release.
REQ-030 Line timing: run one line -> pix_en period 4 clks; raw hsync low for 96 pixels (x 656..751); output hsync edge 2 clks after the raw edge.
REQ-031 Line wrap: x=799 on pix_en -> x=0 and y increments on the same edge; y=524 with x wrap -> y=0 and frame_start pulses exactly 1 clk.
REQ-032 Frame: run 2 full frames -> 420000 pix_en pulses per frame, vsync low for exactly 2 lines (y 490..491), video_on high for 307200 pixels per frame.
REQ-033 Mid-frame reset: assert rst_n low at x=300, y=200 between clk edges -> outputs take reset values immediately; recount from 0 after release.
REQ-034 Alignment: score_sprite at pos (0,0) with SYNC_DLY=2 -> first sprite rgb word coincides with the first video_on-high clk.
